// File: rtl/board_ctrl.sv
// Tic-tac-toe board datapath driven by the game FSM's state code.
// It holds the 3x3 board, runs the per-turn timer and picks the target cell.
// It writes moves and reports timeout/occupied/game-over back to the FSM.
module board_ctrl #(
    parameter int unsigned TURN_CYCLES = 500_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  estados,
    input  logic [3:0]  cursor,
    output logic        timeout,
    output logic        ocupado,
    output logic        ganado,
    output logic [17:0] board,
    output logic        turno,
    output logic [1:0]  winner
);

    localparam int CNT_W = $clog2(TURN_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TURN_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE  = 3'b000,
        S_WAIT  = 3'b001,
        S_POLL  = 3'b010,
        S_CHECK = 3'b011,
        S_AUTO  = 3'b100,
        S_WRITE = 3'b101,
        S_EVAL  = 3'b110,
        S_END   = 3'b111
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] count;
    logic [3:0]       target;
    logic [3:0]       moves;
    logic [1:0]       target_cell;
    logic             line_done;

    assign state = state_t'(estados);

    // Code stored in cell i; indices 9..15 read as empty.
    function automatic logic [1:0] cell_at(input logic [17:0] b, input logic [3:0] idx);
        logic [1:0] c;
        c = 2'b00;
        for (int k = 0; k < 9; k++) begin
            if (idx == 4'(k)) c = b[2*k +: 2];
        end
        return c;
    endfunction

    // Three cells hold the same player's mark.
    function automatic logic same3(input logic [1:0] a, input logic [1:0] b2, input logic [1:0] c);
        return (a != 2'b00) && (a == b2) && (a == c);
    endfunction

    // Any of the 8 winning lines complete.
    function automatic logic any_line(input logic [17:0] b);
        logic [1:0] c [9];
        for (int k = 0; k < 9; k++) c[k] = b[2*k +: 2];
        return same3(c[0], c[1], c[2]) | same3(c[3], c[4], c[5]) |
               same3(c[6], c[7], c[8]) | same3(c[0], c[3], c[6]) |
               same3(c[1], c[4], c[7]) | same3(c[2], c[5], c[8]) |
               same3(c[0], c[4], c[8]) | same3(c[2], c[4], c[6]);
    endfunction

    // Lowest-index empty cell, or 4'hF when the board is full.
    function automatic logic [3:0] first_empty(input logic [17:0] b);
        logic [3:0] idx;
        idx = 4'hF;
        for (int k = 8; k >= 0; k--) begin
            if (b[2*k +: 2] == 2'b00) idx = 4'(k);
        end
        return idx;
    endfunction

    // Status flags derived directly from the registers so the FSM sees them with no lag.
    always_comb begin
        target_cell = cell_at(board, target);
        line_done   = any_line(board);
        timeout     = (count == CNT_MAX);
        ocupado     = (target > 4'd8) || (target_cell != 2'b00);
        ganado      = line_done || (moves == 4'd9);
    end

    // Board, turn, winner, timer, target and move-count updates keyed on the FSM state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            board  <= '0;
            turno  <= 1'b0;
            winner <= 2'b00;
            count  <= '0;
            target <= 4'd0;
            moves  <= 4'd0;
        end else begin
            // The timer only runs while the player is deciding.
            if (state != S_WAIT && state != S_POLL) count <= '0;

            case (state)
                S_IDLE: begin
                    board <= '0;
                    moves <= 4'd0;
                    turno <= 1'b0;
                end
                S_WAIT: begin
                    target <= cursor;
                    if (count != CNT_MAX) count <= count + CNT_W'(1);
                end
                S_POLL: begin
                    if (count != CNT_MAX) count <= count + CNT_W'(1);
                end
                S_CHECK: begin
                end
                S_AUTO: begin
                    target <= first_empty(board);
                end
                S_WRITE: begin
                    // No moves yet means this is the first write of a new game.
                    if (moves == 4'd0) winner <= 2'b00;
                    if (target <= 4'd8 && target_cell == 2'b00) begin
                        board[2*target +: 2] <= turno ? 2'b10 : 2'b01;
                        moves <= moves + 4'd1;
                    end
                end
                S_EVAL: begin
                    if (!ganado) turno <= ~turno;
                end
                S_END: begin
                    // Turn was not flipped on the final move, so turno is the mover.
                    winner <= line_done ? (turno ? 2'b10 : 2'b01) : 2'b00;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_board_ctrl.sv
// Scoreboard bench for board_ctrl: stimulus queues expected values, a monitor checks them.
module tb_board_ctrl;

    localparam int unsigned TC = 8;
    localparam int K_BOARD = 0, K_TURNO = 1, K_WIN = 2, K_TO = 3, K_OC = 4, K_GAN = 5;

    logic        clk;
    logic        rst;
    logic [2:0]  estados;
    logic [3:0]  cursor;
    logic        timeout, ocupado, ganado, turno;
    logic [17:0] board;
    logic [1:0]  winner;

    typedef struct {
        int          kind;
        logic [17:0] val;
        string       name;
    } exp_t;

    exp_t        q[$];
    exp_t        e;
    logic [17:0] act;
    int          errors = 0;
    int          checks = 0;

    logic [17:0] sb;
    logic        st;

    board_ctrl #(.TURN_CYCLES(TC)) dut (
        .clk(clk), .rst(rst), .estados(estados), .cursor(cursor),
        .timeout(timeout), .ocupado(ocupado), .ganado(ganado),
        .board(board), .turno(turno), .winner(winner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: drain every expectation queued during this cycle.
    always @(negedge clk) begin
        while (q.size() > 0) begin
            e = q.pop_front();
            case (e.kind)
                K_BOARD: act = board;
                K_TURNO: act = 18'(turno);
                K_WIN:   act = 18'(winner);
                K_TO:    act = 18'(timeout);
                K_OC:    act = 18'(ocupado);
                default: act = 18'(ganado);
            endcase
            checks++;
            if (act !== e.val) begin
                errors++;
                $display("FAIL %s: got %h expected %h", e.name, act, e.val);
            end
        end
    end

    task automatic check_now(input logic [17:0] a, input logic [17:0] v, input string n);
        checks++;
        if (a !== v) begin
            errors++;
            $display("FAIL %s: got %h expected %h (direct)", n, a, v);
        end
    endtask

    task automatic expect_v(input int k, input logic [17:0] v, input string n);
        exp_t x;
        x.kind = k;
        x.val  = v;
        x.name = n;
        q.push_back(x);
    endtask

    task automatic step(input logic [2:0] s, input logic [3:0] c);
        estados = s;
        cursor  = c;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_cleared(input string n);
        expect_v(K_BOARD, 18'd0, {n, "_board"});
        expect_v(K_TURNO, 18'd0, {n, "_turno"});
        expect_v(K_WIN,   18'd0, {n, "_winner"});
        expect_v(K_TO,    18'd0, {n, "_timeout"});
        expect_v(K_OC,    18'd0, {n, "_ocupado"});
        expect_v(K_GAN,   18'd0, {n, "_ganado"});
    endtask

    task automatic new_game();
        step(3'b000, 4'd0);
        sb = '0;
        st = 1'b0;
    endtask

    // One full player turn: WAIT -> CHECK -> WRITE -> EVAL.
    task automatic move(input int c, input logic g);
        step(3'b001, 4'(c));
        step(3'b011, 4'(c));
        expect_v(K_OC, 18'd0, "move_ocupado");
        step(3'b101, 4'(c));
        sb[2*c +: 2] = st ? 2'b10 : 2'b01;
        expect_v(K_BOARD, sb, "move_board");
        expect_v(K_GAN, 18'(g), "move_ganado");
        step(3'b110, 4'(c));
        if (!g) st = ~st;
        expect_v(K_TURNO, 18'(st), "move_turno");
    endtask

    initial begin
        rst = 1'b0; estados = 3'b000; cursor = 4'd0;
        sb = '0; st = 1'b0;
        step(3'b000, 4'd0);
        check_now(board, 18'd0, "reset_board");
        check_now(18'(turno), 18'd0, "reset_turno");
        check_now(18'(winner), 18'd0, "reset_winner");
        check_now(18'(timeout), 18'd0, "reset_timeout");
        check_now(18'(ocupado), 18'd0, "reset_ocupado");
        check_now(18'(ganado), 18'd0, "reset_ganado");
        rst = 1'b1;

        // First X move into the centre.
        new_game();
        move(4, 1'b0);

        // Occupied and invalid targets.
        step(3'b001, 4'd4);
        step(3'b011, 4'd4);
        expect_v(K_OC, 18'd1, "occupied_ocupado");
        expect_v(K_BOARD, sb, "occupied_board");
        step(3'b001, 4'd9);
        step(3'b011, 4'd9);
        expect_v(K_OC, 18'd1, "invalid_ocupado");
        step(3'b101, 4'd9);
        expect_v(K_BOARD, sb, "invalid_nowrite");

        // Reset in the middle of a game.
        rst = 1'b0;
        step(3'b011, 4'd0);
        expect_cleared("midreset");
        rst = 1'b1;

        // Turn timer and auto-pick.
        new_game();
        move(0, 1'b0);
        move(1, 1'b0);
        for (int i = 1; i <= 9; i++) begin
            step((i % 2) ? 3'b001 : 3'b010, 4'd0);
            if (i == 7) check_now(18'(timeout), 18'd0, "timeout_early");
            if (i == 8) check_now(18'(timeout), 18'd1, "timeout_at_limit");
            if (i == 9) check_now(18'(timeout), 18'd1, "timeout_saturated");
        end
        step(3'b100, 4'd0);
        expect_v(K_TO, 18'd0, "timeout_cleared");
        step(3'b011, 4'd0);
        expect_v(K_OC, 18'd0, "auto_ocupado");
        step(3'b101, 4'd0);
        sb[5:4] = 2'b01;
        expect_v(K_BOARD, sb, "auto_write_cell2");
        expect_v(K_GAN, 18'd0, "auto_ganado");

        // X wins on the diagonal.
        new_game();
        move(0, 1'b0);
        move(1, 1'b0);
        move(4, 1'b0);
        move(2, 1'b0);
        move(8, 1'b1);
        step(3'b111, 4'd0);
        expect_v(K_WIN, 18'd1, "win_x");
        step(3'b000, 4'd0);
        sb = '0; st = 1'b0;
        expect_v(K_WIN, 18'd1, "winner_held_idle");
        expect_v(K_BOARD, 18'd0, "idle_board");

        // Draw: full board with no line.
        move(0, 1'b0);
        expect_v(K_WIN, 18'd0, "winner_cleared_first_write");
        move(1, 1'b0);
        move(2, 1'b0);
        move(4, 1'b0);
        move(3, 1'b0);
        move(5, 1'b0);
        move(7, 1'b0);
        move(6, 1'b0);
        move(8, 1'b1);
        step(3'b111, 4'd0);
        expect_v(K_WIN, 18'd0, "draw_winner");
        expect_v(K_BOARD, 18'h16A59, "draw_board");
        step(3'b100, 4'd0);
        expect_v(K_OC, 18'd1, "auto_full_ocupado");

        // Reset wins over a pending write.
        new_game();
        step(3'b001, 4'd4);
        step(3'b011, 4'd4);
        expect_v(K_OC, 18'd0, "pre_reset_ocupado");
        rst = 1'b0;
        step(3'b101, 4'd4);
        expect_v(K_BOARD, 18'd0, "reset_over_write_board");
        expect_v(K_OC, 18'd0, "reset_over_write_ocupado");
        rst = 1'b1;
        step(3'b000, 4'd0);

        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
